cpu_datapath: RTL and testbench

- Combinational instruction decoder, 4×16-bit register file and registered 16-bit ALU with a flag register, in one datapath block.
- Sits under the CPU sequencer, which supplies the fetched instruction word and register/ALU write strobes, and consumes the decoded fields, operands, results and the branch decision.

---
 rtl/cpu_datapath.sv | 192 +++++++++++++++++++
 tb/tb_cpu_datapath.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_datapath.sv
// Datapath: instruction field decoder, 4x16 register file and a registered ALU with flags.
// Optional feature: define ALU_MUL_EN to turn two-operand op 8 into MUL (low 16 bits of product).
module cpu_datapath #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NREGS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      word,
    input  logic [1:0]       reg_write,
    input  logic [WIDTH-1:0] reg_in,
    input  logic             alu_en,
    output logic [3:0]       operator_group,
    output logic [3:0]       operator,
    output logic [2:0]       rgv,
    output logic [7:0]       val,
    output logic [2:0]       rg1,
    output logic [2:0]       rg2,
    output logic [9:0]       relative_addr,
    output logic [WIDTH-1:0] reg_out1,
    output logic [WIDTH-1:0] reg_out2,
    output logic [WIDTH-1:0] alu_out,
    output logic [5:0]       alu_flags,
    output logic             check_branch
);

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];
    logic [WIDTH-1:0] alu_out_q, alu_out_d;
    logic [5:0]       alu_flags_q, alu_flags_d;

    logic             single;
    logic [WIDTH-1:0] value1, value2, result;
    logic [WIDTH:0]   wide;
    logic             c_flag, v_flag, load_out;
`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] product;
`endif

    assign operator_group = word[15:12];
    assign operator       = word[11:8];
    assign rgv            = word[10:8];
    assign val            = word[7:0];
    assign rg1            = word[5:3];
    assign rg2            = word[2:0];
    assign relative_addr  = word[9:0];

    assign reg_out1  = regs_q[rg1[2:1]];
    assign reg_out2  = regs_q[rg2[2:1]];
    assign alu_out   = alu_out_q;
    assign alu_flags = alu_flags_q;

    // Both write strobes to the same index collapse into one write of reg_in.
    always_comb begin
        regs_d = regs_q;
        if (reg_write[0]) regs_d[rg1[2:1]] = reg_in;
        if (reg_write[1]) regs_d[rg2[2:1]] = reg_in;
    end

    always_comb begin
        single = (operator_group == 4'd1) || (operator_group == 4'd2);
        if (operator_group == 4'd8) begin
            value1 = regs_q[rgv[2:1]];
            value2 = {8'h00, val};
        end else begin
            value1 = reg_out1;
            value2 = reg_out2;
        end
    end

    // Subtractive ops report borrow in C via bit WIDTH of the 17-bit difference.
    always_comb begin
        wide     = '0;
        result   = value1;
        c_flag   = 1'b0;
        v_flag   = 1'b0;
        load_out = 1'b1;
`ifdef ALU_MUL_EN
        product  = {{WIDTH{1'b0}}, value1} * {{WIDTH{1'b0}}, value2};
`endif
        if (!single) begin
            case (operator)
                4'd0, 4'd5: begin
                    wide   = {1'b0, value1} + {1'b0, value2}
                           + {{WIDTH{1'b0}}, (operator == 4'd5) & alu_flags_q[0]};
                    result = wide[WIDTH-1:0];
                    c_flag = wide[WIDTH];
                    v_flag = (value1[WIDTH-1] == value2[WIDTH-1])
                           && (result[WIDTH-1] != value1[WIDTH-1]);
                end
                4'd1, 4'd6, 4'd7: begin
                    wide     = {1'b0, value1} - {1'b0, value2}
                             - {{WIDTH{1'b0}}, (operator == 4'd6) & alu_flags_q[0]};
                    result   = wide[WIDTH-1:0];
                    c_flag   = wide[WIDTH];
                    v_flag   = (value1[WIDTH-1] != value2[WIDTH-1])
                             && (result[WIDTH-1] != value1[WIDTH-1]);
                    load_out = (operator != 4'd7);
                end
                4'd2: result = value1 & value2;
                4'd3: result = value1 | value2;
                4'd4: result = value1 ^ value2;
`ifdef ALU_MUL_EN
                4'd8: begin
                    result = product[WIDTH-1:0];
                    c_flag = |product[2*WIDTH-1:WIDTH];
                end
`endif
                default: result = value1;
            endcase
        end else begin
            case (operator)
                4'd0: result = ~value1;
                4'd1: begin
                    wide   = {(WIDTH+1){1'b0}} - {1'b0, value1};
                    result = wide[WIDTH-1:0];
                    c_flag = wide[WIDTH];
                    v_flag = (value1 == {1'b1, {(WIDTH-1){1'b0}}});
                end
                4'd2: begin
                    wide   = {1'b0, value1} + {{WIDTH{1'b0}}, 1'b1};
                    result = wide[WIDTH-1:0];
                    c_flag = wide[WIDTH];
                    v_flag = (value1 == {1'b0, {(WIDTH-1){1'b1}}});
                end
                4'd3: begin
                    wide   = {1'b0, value1} - {{WIDTH{1'b0}}, 1'b1};
                    result = wide[WIDTH-1:0];
                    c_flag = wide[WIDTH];
                    v_flag = (value1 == {1'b1, {(WIDTH-1){1'b0}}});
                end
                4'd4: begin
                    result = {value1[WIDTH-2:0], 1'b0};
                    c_flag = value1[WIDTH-1];
                end
                4'd5: begin
                    result = {1'b0, value1[WIDTH-1:1]};
                    c_flag = value1[0];
                end
                4'd6: begin
                    result = {value1[WIDTH-2:0], value1[WIDTH-1]};
                    c_flag = value1[WIDTH-1];
                end
                4'd7: begin
                    result = {value1[WIDTH-1], value1[WIDTH-1:1]};
                    c_flag = value1[0];
                end
                default: result = value1;
            endcase
        end
    end

    always_comb begin
        alu_out_d   = alu_out_q;
        alu_flags_d = alu_flags_q;
        if (alu_en) begin
            if (load_out) alu_out_d = result;
            alu_flags_d = {!single && (value1 == value2), ~^result, v_flag,
                           result[WIDTH-1], (result == '0), c_flag};
        end
    end

    // Flag order {E,P,V,N,Z,C}: C=0, Z=1, N=2, V=3, P=4, E=5.
    always_comb begin
        case (operator)
            4'd0:    check_branch = 1'b1;
            4'd1:    check_branch = alu_flags_q[1];
            4'd2:    check_branch = !alu_flags_q[1];
            4'd3:    check_branch = alu_flags_q[0];
            4'd4:    check_branch = !alu_flags_q[0];
            4'd5:    check_branch = alu_flags_q[2];
            4'd6:    check_branch = !alu_flags_q[2];
            4'd7:    check_branch = alu_flags_q[3];
            4'd8:    check_branch = !alu_flags_q[3];
            4'd9:    check_branch = alu_flags_q[5];
            default: check_branch = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q      <= '{default: '0};
            alu_out_q   <= '0;
            alu_flags_q <= '0;
        end else begin
            regs_q      <= regs_d;
            alu_out_q   <= alu_out_d;
            alu_flags_q <= alu_flags_d;
        end
    end

endmodule

// File: tb/tb_cpu_datapath.sv
// Self-checking bench for cpu_datapath: decode/ALU vector tables, directed sequences and
// randomized traffic against an arithmetic reference model.
module tb_cpu_datapath;

    logic        clk, reset, alu_en, check_branch;
    logic [15:0] word, reg_in, reg_out1, reg_out2, alu_out;
    logic [1:0]  reg_write;
    logic [3:0]  operator_group, operator;
    logic [2:0]  rgv, rg1, rg2;
    logic [7:0]  val;
    logic [9:0]  relative_addr;
    logic [5:0]  alu_flags;

    int checks = 0;
    int errors = 0;

    int     mregs[4];
    int     mout;
    bit [5:0] mflags;

    typedef struct {
        logic [15:0] w;
        logic [3:0]  grp, op;
        logic [2:0]  rgv;
        logic [7:0]  val;
        logic [2:0]  r1, r2;
        logic [9:0]  rel;
    } dec_vec_t;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] res;
        logic [5:0]  flags;
    } alu_vec_t;

    dec_vec_t dv[5];
    alu_vec_t av[8];

    cpu_datapath #(.WIDTH(16), .NREGS(4)) dut (
        .clk(clk), .reset(reset), .word(word), .reg_write(reg_write), .reg_in(reg_in),
        .alu_en(alu_en), .operator_group(operator_group), .operator(operator), .rgv(rgv),
        .val(val), .rg1(rg1), .rg2(rg2), .relative_addr(relative_addr),
        .reg_out1(reg_out1), .reg_out2(reg_out2), .alu_out(alu_out), .alu_flags(alu_flags),
        .check_branch(check_branch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic int sg(input int a);
        return (a >= 32768) ? a - 65536 : a;
    endfunction

    function automatic bit ovf(input int x);
        return (x > 32767) || (x < -32768);
    endfunction

    function automatic void model_alu(input int g, input int o, input int a, input int b,
                                      input int cin, output int res, output bit [5:0] fl,
                                      output bit upd);
        int s, c, v;
        longint prod;
        bit single;
        logic [15:0] r16;
        single = (g == 1) || (g == 2);
        res = a; c = 0; v = 0; upd = 1;
        if (!single) begin
            case (o)
                0: begin s = a + b; res = s % 65536; c = s > 65535; v = ovf(sg(a) + sg(b)); end
                5: begin s = a + b + cin; res = s % 65536; c = s > 65535;
                         v = ovf(sg(a) + sg(b) + cin); end
                1, 7: begin s = a - b; res = (s + 65536) % 65536; c = s < 0;
                            v = ovf(sg(a) - sg(b)); upd = (o != 7); end
                6: begin s = a - b - cin; res = (s + 65536) % 65536; c = s < 0;
                         v = ovf(sg(a) - sg(b) - cin); end
                2: res = a & b;
                3: res = a | b;
                4: res = a ^ b;
`ifdef ALU_MUL_EN
                8: begin prod = longint'(a) * longint'(b); res = int'(prod % 65536);
                         c = prod >= 65536; end
`endif
                default: res = a;
            endcase
        end else begin
            case (o)
                0: res = 65535 - a;
                1: begin res = (65536 - a) % 65536; c = a != 0; v = ovf(-sg(a)); end
                2: begin res = (a + 1) % 65536; c = a == 65535; v = ovf(sg(a) + 1); end
                3: begin res = (a + 65535) % 65536; c = a == 0; v = ovf(sg(a) - 1); end
                4: begin res = (a * 2) % 65536; c = a / 32768; end
                5: begin res = a / 2; c = a % 2; end
                6: begin res = (a * 2) % 65536 + a / 32768; c = a / 32768; end
                7: begin res = a / 2 + ((a >= 32768) ? 32768 : 0); c = a % 2; end
                default: res = a;
            endcase
        end
        r16 = res[15:0];
        fl = {!single && (a == b), ($countones(r16) % 2) == 0, v[0], res >= 32768,
              res == 0, c[0]};
    endfunction

    function automatic bit model_branch(input int o, input bit [5:0] f);
        case (o)
            0: return 1'b1;
            1: return f[1];
            2: return !f[1];
            3: return f[0];
            4: return !f[0];
            5: return f[2];
            6: return !f[2];
            7: return f[3];
            8: return !f[3];
            9: return f[5];
            default: return 1'b0;
        endcase
    endfunction

    task automatic apply(input logic [15:0] w, input logic [1:0] rw, input logic [15:0] rin,
                         input logic en, input logic rst);
        @(negedge clk);
        word = w; reg_write = rw; reg_in = rin; alu_en = en; reset = rst;
        #1;
    endtask

    // Advance one clock edge, updating the reference model from the inputs held across it.
    task automatic tick();
        int g, o, a, b, res;
        bit [5:0] fl;
        bit upd;
        logic [15:0] w, rin;
        logic [1:0] rw;
        logic en, rst;
        w = word; rin = reg_in; rw = reg_write; en = alu_en; rst = reset;
        g = int'(w[15:12]); o = int'(w[11:8]);
        if (g == 8) begin a = mregs[w[10:9]]; b = int'(w[7:0]); end
        else begin a = mregs[w[5:4]]; b = mregs[w[2:1]]; end
        model_alu(g, o, a, b, int'(mflags[0]), res, fl, upd);
        @(posedge clk);
        #1;
        if (rst) begin
            for (int i = 0; i < 4; i++) mregs[i] = 0;
            mout = 0; mflags = '0;
        end else begin
            if (rw[0]) mregs[w[5:4]] = int'(rin);
            if (rw[1]) mregs[w[2:1]] = int'(rin);
            if (en) begin
                mflags = fl;
                if (upd) mout = res;
            end
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_reg_out1"}, reg_out1, mregs[word[5:4]]);
        chk({tag, "_reg_out2"}, reg_out2, mregs[word[2:1]]);
        chk({tag, "_alu_out"}, alu_out, mout);
        chk({tag, "_alu_flags"}, alu_flags, mflags);
        chk({tag, "_branch"}, check_branch, model_branch(int'(word[11:8]), mflags));
    endtask

    initial begin
        logic [15:0] specials[5];
        logic [31:0] r;
        logic [3:0]  g4, o4;
        specials = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};

        dv[0] = '{16'h0A2B, 4'h0, 4'hA, 3'd2, 8'h2B, 3'd5, 3'd3, 10'h22B};
        dv[1] = '{16'h7F81, 4'h7, 4'hF, 3'd7, 8'h81, 3'd0, 3'd1, 10'h381};
        dv[2] = '{16'hFFFF, 4'hF, 4'hF, 3'd7, 8'hFF, 3'd7, 3'd7, 10'h3FF};
        dv[3] = '{16'h8C3A, 4'h8, 4'hC, 3'd4, 8'h3A, 3'd7, 3'd2, 10'h03A};
        dv[4] = '{16'h0000, 4'h0, 4'h0, 3'd0, 8'h00, 3'd0, 3'd0, 10'h000};

        // Single-operand ops applied to 16'h8001.
        av[0] = '{4'd0, 16'h7FFE, 6'h10};
        av[1] = '{4'd1, 16'h7FFF, 6'h01};
        av[2] = '{4'd2, 16'h8002, 6'h14};
        av[3] = '{4'd3, 16'h8000, 6'h04};
        av[4] = '{4'd4, 16'h0002, 6'h01};
        av[5] = '{4'd5, 16'h4000, 6'h01};
        av[6] = '{4'd6, 16'h0003, 6'h11};
        av[7] = '{4'd7, 16'hC000, 6'h15};

        for (int i = 0; i < 4; i++) mregs[i] = 0;
        mout = 0; mflags = '0;
        word = '0; reg_write = '0; reg_in = '0; alu_en = 1'b0; reset = 1'b1;

        apply(16'h0000, 2'b00, 16'h0000, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) begin
            logic [15:0] w;
            w = 16'h0000;
            w[5:4] = i[1:0];
            w[2:1] = i[1:0];
            apply(w, 2'b00, 16'h0000, 1'b0, 1'b0);
            chk("reset_reg_out1", reg_out1, 16'h0000);
            chk("reset_reg_out2", reg_out2, 16'h0000);
        end
        chk("reset_alu_out", alu_out, 16'h0000);
        chk("reset_alu_flags", alu_flags, 6'h00);

        foreach (dv[i]) begin
            apply(dv[i].w, 2'b00, 16'h0000, 1'b0, 1'b0);
            chk("dec_group", operator_group, dv[i].grp);
            chk("dec_operator", operator, dv[i].op);
            chk("dec_rgv", rgv, dv[i].rgv);
            chk("dec_val", val, dv[i].val);
            chk("dec_rg1", rg1, dv[i].r1);
            chk("dec_rg2", rg2, dv[i].r2);
            chk("dec_rel", relative_addr, dv[i].rel);
        end

        apply(16'h0000, 2'b01, 16'h8001, 1'b0, 1'b0);
        tick();
        foreach (av[i]) begin
            apply({4'h1, av[i].op, 8'h00}, 2'b00, 16'h0000, 1'b1, 1'b0);
            tick();
            chk("single_res", alu_out, av[i].res);
            chk("single_flags", alu_flags, av[i].flags);
        end

        apply(16'h0010, 2'b01, 16'h7FFF, 1'b0, 1'b0); tick();
        apply(16'h0020, 2'b01, 16'h0001, 1'b0, 1'b0); tick();
        apply(16'h0014, 2'b00, 16'h0000, 1'b1, 1'b0); tick();
        chk("add_out", alu_out, 16'h8000);
        chk("add_flags", alu_flags, 6'h0C);

        apply(16'h0010, 2'b01, 16'h0005, 1'b0, 1'b0); tick();
        apply(16'h0020, 2'b01, 16'h0007, 1'b0, 1'b0); tick();
        apply(16'h0114, 2'b00, 16'h0000, 1'b1, 1'b0); tick();
        chk("sub_out", alu_out, 16'hFFFE);
        chk("sub_flags", alu_flags, 6'h05);
        apply(16'h0020, 2'b01, 16'h0005, 1'b0, 1'b0); tick();
        apply(16'h0714, 2'b00, 16'h0000, 1'b1, 1'b0); tick();
        chk("cmp_out_held", alu_out, 16'hFFFE);
        chk("cmp_flags", alu_flags, 6'h32);

        apply(16'h7100, 2'b00, 16'h0000, 1'b0, 1'b0); chk("br_z", check_branch, 1'b1);
        apply(16'h7200, 2'b00, 16'h0000, 1'b0, 1'b0); chk("br_nz", check_branch, 1'b0);
        apply(16'h7000, 2'b00, 16'h0000, 1'b0, 1'b0); chk("br_always", check_branch, 1'b1);
        apply(16'h7900, 2'b00, 16'h0000, 1'b0, 1'b0); chk("br_e", check_branch, 1'b1);
        apply(16'h7300, 2'b00, 16'h0000, 1'b0, 1'b0); chk("br_c", check_branch, 1'b0);

        apply(16'h0010, 2'b01, 16'h1234, 1'b0, 1'b0);
        chk("rw_same_old", reg_out1, 16'h0005);
        tick();
        chk("rw_same_new", reg_out1, 16'h1234);

        apply(16'h0014, 2'b11, 16'hFFFF, 1'b1, 1'b1);
        tick();
        chk("rst_wins_r1", reg_out1, 16'h0000);
        chk("rst_wins_r2", reg_out2, 16'h0000);
        chk("rst_wins_out", alu_out, 16'h0000);
        chk("rst_wins_flags", alu_flags, 6'h00);

        for (int it = 0; it < 400; it++) begin
            r = $urandom();
            case ($urandom_range(0, 5))
                0: g4 = 4'h0;
                1: g4 = 4'h1;
                2: g4 = 4'h2;
                3: g4 = 4'h8;
                4: g4 = 4'h7;
                default: g4 = r[31:28];
            endcase
            o4 = ($urandom_range(0, 7) == 0) ? r[27:24] : 4'($urandom_range(0, 9));
            apply({g4, o4, r[7:0]}, r[9:8],
                  r[10] ? specials[$urandom_range(0, 4)] : r[27:12],
                  r[11], ($urandom_range(0, 39) == 0));
            check_model("rnd_pre");
            tick();
            check_model("rnd_post");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
